mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 216 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: the MEM pipeline register, plus a bus master that performs
// one aligned word load or store per instruction and busies the pipeline meanwhile.
//   state     | meaning
//   ST_IDLE   | no transaction; starts one for an aligned, clean access
//   ST_REQ    | bus requested, waiting for grant
//   ST_ACCESS | address strobed, waiting for ready
//   ST_STALL  | access done, pipeline still stalled; load data held in rd_buf
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] ex_pc,
  input  logic        ex_en,
  input  logic        ex_br_flag,
  input  logic [1:0]  ex_ctrl_op,
  input  logic [4:0]  ex_dst_addr,
  input  logic        ex_gpr_we_,
  input  logic [2:0]  ex_exp_code,
  input  logic [1:0]  ex_mem_op,
  input  logic [31:0] ex_mem_wr_data,
  input  logic [31:0] ex_out,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_,
  output logic        busy,
  output logic [29:0] mem_pc,
  output logic        mem_en,
  output logic        mem_br_flag,
  output logic [1:0]  mem_ctrl_op,
  output logic [4:0]  mem_dst_addr,
  output logic        mem_gpr_we_,
  output logic [2:0]  mem_exp_code,
  output logic [31:0] mem_out
);

  localparam logic [1:0] MEM_OP_LDW     = 2'd1;
  localparam logic [1:0] MEM_OP_STW     = 2'd2;
  localparam logic [2:0] EXP_MISS_ALIGN = 3'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACCESS, ST_STALL} state_t;

  state_t      state_q, state_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_as_q, bus_as_d;
  logic        bus_rw_q, bus_rw_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wr_data_q, bus_wr_data_d;

  logic [29:0] mem_pc_q, mem_pc_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_br_flag_q, mem_br_flag_d;
  logic [1:0]  mem_ctrl_op_q, mem_ctrl_op_d;
  logic [4:0]  mem_dst_addr_q, mem_dst_addr_d;
  logic        mem_gpr_we_q, mem_gpr_we_d;
  logic [2:0]  mem_exp_code_q, mem_exp_code_d;
  logic [31:0] mem_out_q, mem_out_d;

  logic        access, miss_align, start;
  logic        busy_c;
  logic [31:0] rd_data;

  assign access     = ex_en && ((ex_mem_op == MEM_OP_LDW) || (ex_mem_op == MEM_OP_STW));
  assign miss_align = access && (ex_out[1:0] != 2'b00);
  // Instructions already carrying an exception never reach the bus.
  assign start      = access && !miss_align && !flush && (ex_exp_code == 3'd0);

  always_comb begin
    state_d       = state_q;
    rd_buf_d      = rd_buf_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = bus_as_q;
    bus_rw_d      = bus_rw_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    busy_c        = 1'b0;
    rd_data       = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_c    = 1'b1;
          bus_req_d = 1'b0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        busy_c = 1'b1;
        if (!bus_grnt_) begin
          bus_as_d      = 1'b0;
          bus_addr_d    = ex_out[31:2];
          bus_rw_d      = (ex_mem_op == MEM_OP_LDW);
          bus_wr_data_d = ex_mem_wr_data;
          state_d       = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        bus_as_d = 1'b1;
        if (!bus_rdy_) begin
          rd_data       = bus_rd_data;
          rd_buf_d      = bus_rd_data;
          bus_req_d     = 1'b1;
          bus_rw_d      = 1'b1;
          bus_addr_d    = 30'd0;
          bus_wr_data_d = 32'd0;
          state_d       = stall ? ST_STALL : ST_IDLE;
        end else begin
          busy_c = 1'b1;
        end
      end
      ST_STALL: begin
        rd_data = rd_buf_q;
        if (!stall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_pc_d       = mem_pc_q;
    mem_en_d       = mem_en_q;
    mem_br_flag_d  = mem_br_flag_q;
    mem_ctrl_op_d  = mem_ctrl_op_q;
    mem_dst_addr_d = mem_dst_addr_q;
    mem_gpr_we_d   = mem_gpr_we_q;
    mem_exp_code_d = mem_exp_code_q;
    mem_out_d      = mem_out_q;
    if (!stall) begin
      if (flush) begin
        mem_pc_d       = 30'd0;
        mem_en_d       = 1'b0;
        mem_br_flag_d  = 1'b0;
        mem_ctrl_op_d  = 2'd0;
        mem_dst_addr_d = 5'd0;
        mem_gpr_we_d   = 1'b1;
        mem_exp_code_d = 3'd0;
        mem_out_d      = 32'd0;
      end else if (miss_align) begin
        mem_pc_d       = ex_pc;
        mem_en_d       = ex_en;
        mem_br_flag_d  = ex_br_flag;
        mem_ctrl_op_d  = 2'd0;
        mem_dst_addr_d = 5'd0;
        mem_gpr_we_d   = 1'b1;
        mem_exp_code_d = EXP_MISS_ALIGN;
        mem_out_d      = 32'd0;
      end else begin
        mem_pc_d       = ex_pc;
        mem_en_d       = ex_en;
        mem_br_flag_d  = ex_br_flag;
        mem_ctrl_op_d  = ex_ctrl_op;
        mem_dst_addr_d = ex_dst_addr;
        mem_gpr_we_d   = ex_gpr_we_;
        mem_exp_code_d = ex_exp_code;
        mem_out_d      = (ex_mem_op == MEM_OP_LDW) ? rd_data : ex_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      rd_buf_q       <= 32'd0;
      bus_req_q      <= 1'b1;
      bus_as_q       <= 1'b1;
      bus_rw_q       <= 1'b1;
      bus_addr_q     <= 30'd0;
      bus_wr_data_q  <= 32'd0;
      mem_pc_q       <= 30'd0;
      mem_en_q       <= 1'b0;
      mem_br_flag_q  <= 1'b0;
      mem_ctrl_op_q  <= 2'd0;
      mem_dst_addr_q <= 5'd0;
      mem_gpr_we_q   <= 1'b1;
      mem_exp_code_q <= 3'd0;
      mem_out_q      <= 32'd0;
    end else begin
      state_q        <= state_d;
      rd_buf_q       <= rd_buf_d;
      bus_req_q      <= bus_req_d;
      bus_as_q       <= bus_as_d;
      bus_rw_q       <= bus_rw_d;
      bus_addr_q     <= bus_addr_d;
      bus_wr_data_q  <= bus_wr_data_d;
      mem_pc_q       <= mem_pc_d;
      mem_en_q       <= mem_en_d;
      mem_br_flag_q  <= mem_br_flag_d;
      mem_ctrl_op_q  <= mem_ctrl_op_d;
      mem_dst_addr_q <= mem_dst_addr_d;
      mem_gpr_we_q   <= mem_gpr_we_d;
      mem_exp_code_q <= mem_exp_code_d;
      mem_out_q      <= mem_out_d;
    end
  end

  assign busy         = busy_c;
  assign bus_req_     = bus_req_q;
  assign bus_as_      = bus_as_q;
  assign bus_rw       = bus_rw_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wr_data  = bus_wr_data_q;
  assign mem_pc       = mem_pc_q;
  assign mem_en       = mem_en_q;
  assign mem_br_flag  = mem_br_flag_q;
  assign mem_ctrl_op  = mem_ctrl_op_q;
  assign mem_dst_addr = mem_dst_addr_q;
  assign mem_gpr_we_  = mem_gpr_we_q;
  assign mem_exp_code = mem_exp_code_q;
  assign mem_out      = mem_out_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: acts as upstream EX stage, pipeline controller and bus slave;
// expected MEM register contents and bus transactions are queued at issue time.
module tb_mem_stage;

  logic        clk, reset, stall, flush, ext_stall;
  logic [29:0] ex_pc;
  logic        ex_en, ex_br_flag, ex_gpr_we_;
  logic [1:0]  ex_ctrl_op, ex_mem_op;
  logic [4:0]  ex_dst_addr;
  logic [2:0]  ex_exp_code;
  logic [31:0] ex_mem_wr_data, ex_out;
  logic        bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_, busy;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data, bus_rd_data;
  logic [29:0] mem_pc;
  logic        mem_en, mem_br_flag, mem_gpr_we_;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr;
  logic [2:0]  mem_exp_code;
  logic [31:0] mem_out;

  typedef struct {
    logic [29:0] pc;
    logic        en, br, we_;
    logic [1:0]  ctrl, mop;
    logic [4:0]  dst;
    logic [2:0]  ecode;
    logic [31:0] out, wd, rd;
    int          mode;   // 0 none, 1 flush throughout, 2 flush raised after access starts
    int          n_ext;  // cycles of controller stall from other sources
  } instr_t;

  typedef struct packed {
    logic [29:0] pc;
    logic        en, br;
    logic [1:0]  ctrl;
    logic [4:0]  dst;
    logic        we_;
    logic [2:0]  ecode;
    logic [31:0] out;
  } exp_t;

  typedef struct {
    logic [29:0] addr;
    logic        rw;
    logic [31:0] wd, rd;
  } bus_t;

  exp_t pq[$];
  bus_t bq[$];
  int   checks = 0, errors = 0;
  int   n_txn = 0, n_as = 0;
  int   g_fix = -1, r_fix = -1;
  bit   hold_grant = 0, mon_on = 0;

  assign stall = busy | ext_stall;

  mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_ctrl_op(ex_ctrl_op),
    .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code),
    .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data), .ex_out(ex_out),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_rdy_(bus_rdy_), .busy(busy),
    .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
    .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
    .mem_out(mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic bit is_access(input instr_t it);
    return it.en && (it.mop == 2'd1 || it.mop == 2'd2);
  endfunction

  function automatic bit txn_exp(input instr_t it);
    return is_access(it) && (it.out[1:0] == 2'b00) && (it.ecode == 3'd0) && (it.mode != 1);
  endfunction

  // Reference: what the MEM register must hold once this instruction retires.
  function automatic exp_t model(input instr_t it);
    exp_t e;
    e = '0;
    e.we_ = 1'b1;
    if (it.mode != 0) return e;
    e.pc = it.pc;
    e.en = it.en;
    e.br = it.br;
    if (is_access(it) && it.out[1:0] != 2'b00) begin
      e.ecode = 3'd4;
      return e;
    end
    e.ctrl  = it.ctrl;
    e.dst   = it.dst;
    e.we_   = it.we_;
    e.ecode = it.ecode;
    e.out   = (it.mop == 2'd1) ? it.rd : it.out;
    return e;
  endfunction

  function automatic instr_t mk(input logic [29:0] pc, input logic [1:0] mop, input logic [31:0] out,
                                input logic [31:0] wd, input logic [31:0] rd, input int mode, input int n_ext);
    instr_t it;
    it.pc = pc; it.en = 1'b1; it.br = 1'b1; it.we_ = 1'b0; it.ctrl = 2'd2; it.mop = mop;
    it.dst = 5'd9; it.ecode = 3'd0; it.out = out; it.wd = wd; it.rd = rd;
    it.mode = mode; it.n_ext = n_ext;
    return it;
  endfunction

  task automatic issue(input instr_t it, output int cyc);
    bus_t b;
    bit   done;
    ex_pc = it.pc; ex_en = it.en; ex_br_flag = it.br; ex_ctrl_op = it.ctrl;
    ex_dst_addr = it.dst; ex_gpr_we_ = it.we_; ex_exp_code = it.ecode;
    ex_mem_op = it.mop; ex_mem_wr_data = it.wd; ex_out = it.out;
    flush = (it.mode == 1);
    ext_stall = (it.n_ext > 0);
    pq.push_back(model(it));
    if (txn_exp(it)) begin
      b.addr = it.out[31:2]; b.rw = (it.mop == 2'd1); b.wd = it.wd; b.rd = it.rd;
      bq.push_back(b);
      n_txn++;
    end
    cyc = 0;
    forever begin
      @(negedge clk);
      done = !stall;
      @(posedge clk); #1;
      cyc++;
      if (done) break;
      if (it.mode == 2) flush = 1'b1;
      if (cyc >= it.n_ext) ext_stall = 1'b0;
      if (cyc >= 200) begin
        checks++; errors++;
        $display("FAIL issue_timeout: got %0d cycles expected retire", cyc);
        break;
      end
    end
    flush = 1'b0;
    ext_stall = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_bus_req_"}, bus_req_, 1);
    chk({tag, "_bus_as_"}, bus_as_, 1);
    chk({tag, "_bus_rw"}, bus_rw, 1);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_bus_wr_data"}, bus_wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_pc"}, mem_pc, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_br_flag"}, mem_br_flag, 0);
    chk({tag, "_mem_ctrl_op"}, mem_ctrl_op, 0);
    chk({tag, "_mem_dst_addr"}, mem_dst_addr, 0);
    chk({tag, "_mem_gpr_we_"}, mem_gpr_we_, 1);
    chk({tag, "_mem_exp_code"}, mem_exp_code, 0);
    chk({tag, "_mem_out"}, mem_out, 0);
  endtask

  // Monitor: the MEM register must present the next expected result after every unstalled edge.
  initial begin : monitor
    bit   u;
    exp_t e;
    forever begin
      @(negedge clk);
      u = mon_on && reset && !stall;
      @(posedge clk); #1;
      if (u) begin
        if (pq.size() == 0) begin
          checks++; errors++;
          $display("FAIL pipe_unexpected: got update at t=%0t expected none", $time);
        end else begin
          e = pq.pop_front();
          chk("mem_pc", mem_pc, e.pc);
          chk("mem_en", mem_en, e.en);
          chk("mem_br_flag", mem_br_flag, e.br);
          chk("mem_ctrl_op", mem_ctrl_op, e.ctrl);
          chk("mem_dst_addr", mem_dst_addr, e.dst);
          chk("mem_gpr_we_", mem_gpr_we_, e.we_);
          chk("mem_exp_code", mem_exp_code, e.ecode);
          chk("mem_out", mem_out, e.out);
        end
      end
    end
  end

  // Bus slave: grants after a delay, checks each strobed transaction, answers ready.
  initial begin : slave
    int   gcnt, rcnt;
    bit   pending, prev_as_low;
    bus_t cur;
    gcnt = -1; rcnt = 0; pending = 0; prev_as_low = 0;
    cur = '{default: '0};
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = 32'd0;
    forever begin
      @(posedge clk); #1;
      bus_rdy_ = 1'b1;
      bus_rd_data = $urandom;
      if (!reset) begin
        bus_grnt_ = 1'b1; gcnt = -1; pending = 0; prev_as_low = 0;
        continue;
      end
      if (bus_req_) begin
        bus_grnt_ = 1'b1; gcnt = -1;
        chk("idle_as_", bus_as_, 1);
        chk("idle_rw", bus_rw, 1);
        chk("idle_addr", bus_addr, 0);
        chk("idle_wr_data", bus_wr_data, 0);
      end else if (bus_grnt_ && !hold_grant) begin
        if (gcnt < 0) gcnt = (g_fix >= 0) ? g_fix : $urandom_range(0, 2);
        if (gcnt == 0) bus_grnt_ = 1'b0;
        else gcnt--;
      end
      if (!bus_as_) begin
        n_as++;
        if (prev_as_low) begin
          checks++; errors++;
          $display("FAIL as_pulse: got bus_as_ low two cycles expected one");
        end
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected: got strobe addr %h expected none", bus_addr);
        end else begin
          cur = bq.pop_front();
          chk("bus_addr", bus_addr, cur.addr);
          chk("bus_rw", bus_rw, cur.rw);
          chk("bus_wr_data", bus_wr_data, cur.wd);
          chk("access_req_", bus_req_, 0);
          pending = 1;
          rcnt = (r_fix >= 0) ? r_fix : $urandom_range(0, 2);
        end
      end else if (pending) begin
        chk("hold_addr", bus_addr, cur.addr);
        chk("hold_rw", bus_rw, cur.rw);
        chk("hold_wr_data", bus_wr_data, cur.wd);
      end
      prev_as_low = !bus_as_;
      if (pending) begin
        if (rcnt == 0) begin
          bus_rdy_ = 1'b0; bus_rd_data = cur.rd; pending = 0;
        end else rcnt--;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish expected finish by 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    instr_t it;
    int     cyc, k;
    reset = 1'b0; flush = 1'b0; ext_stall = 1'b0;
    ex_pc = '0; ex_en = 1'b0; ex_br_flag = 1'b0; ex_ctrl_op = '0; ex_dst_addr = '0;
    ex_gpr_we_ = 1'b1; ex_exp_code = '0; ex_mem_op = '0; ex_mem_wr_data = '0; ex_out = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b1;
    mon_on = 1;

    issue(mk(30'h100, 2'd0, 32'h12345678, 32'h0, 32'h0, 0, 0), cyc);
    chk("alu_latency", cyc, 1);
    g_fix = 2; r_fix = 0;
    issue(mk(30'h104, 2'd1, 32'h00000100, 32'h0, 32'hCAFEBABE, 0, 0), cyc);
    g_fix = 0; r_fix = 0;
    issue(mk(30'h108, 2'd2, 32'h00000008, 32'hA5A5A5A5, 32'h0, 0, 0), cyc);
    chk("stw_min_latency", cyc, 3);
    issue(mk(30'h10C, 2'd1, 32'h00000102, 32'h0, 32'h0, 0, 0), cyc);
    chk("miss_align_latency", cyc, 1);
    issue(mk(30'h110, 2'd1, 32'h00000300, 32'h0, 32'h0BADF00D, 0, 6), cyc);
    chk("stall_load_latency", cyc, 7);
    g_fix = 1; r_fix = 1;
    issue(mk(30'h114, 2'd1, 32'h00000400, 32'h0, 32'h11223344, 2, 0), cyc);
    g_fix = -1; r_fix = -1;

    for (int n = 0; n < 300; n++) begin
      it.pc = 30'($urandom);
      it.en = ($urandom_range(0, 7) != 0);
      it.br = 1'($urandom);
      it.ctrl = 2'($urandom);
      it.dst = 5'($urandom);
      it.we_ = 1'($urandom);
      it.ecode = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      it.mop = 2'($urandom);
      it.out = $urandom;
      it.wd = $urandom;
      it.rd = $urandom;
      if ($urandom_range(0, 3) != 0) it.out[1:0] = 2'b00;
      if (it.mop == 2'd1) begin
        it.en = 1'b1; it.ecode = 3'd0;
      end
      it.n_ext = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      it.mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
      if (it.mode == 0 && txn_exp(it) && $urandom_range(0, 7) == 0) it.mode = 2;
      issue(it, cyc);
    end

    issue(mk(30'h3ABCDEF, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0), cyc);
    mon_on = 0;
    hold_grant = 1;
    ex_en = 1'b1; ex_mem_op = 2'd1; ex_out = 32'h00000200; ex_exp_code = 3'd0; flush = 1'b0;
    k = 0;
    while (bus_req_ && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("abort_req_seen", bus_req_, 0);
    reset = 1'b0; ex_en = 1'b0; ex_mem_op = 2'd0;
    @(posedge clk); #1;
    check_reset_state("abort");
    reset = 1'b1;
    hold_grant = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("pipe_queue_empty", pq.size(), 0);
    chk("bus_queue_empty", bq.size(), 0);
    chk("strobe_count", n_as, n_txn);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
